// File: rtl/fifo_drain_serializer_if.sv
//------------------------------------------------------------------------------
// fifo_drain_serializer_if
//
// Narrow output stream of the FIFO drain serializer.
//
// Handshake: a beat transfers on a rising CLK edge where VALID_OUT and
// READY_IN are both high. The master holds DATA_OUT, FIRST_OUT and LAST_OUT
// stable while VALID_OUT is high and READY_IN is low. READY_IN may be driven
// freely by the slave. VALID_OUT does not depend on READY_IN.
//
// Parameter:
//   W          beat width (width_in/ratio of the serializer)
//
// Signals:
//   DATA_OUT   [W-1:0]  current beat
//   VALID_OUT           beat valid
//   READY_IN            downstream accepts beat
//   FIRST_OUT           beat is the first emitted slice of its word
//   LAST_OUT            beat is the last emitted slice of its word
//
// Modports: master (serializer side), slave (consumer side).
//------------------------------------------------------------------------------
interface fifo_drain_serializer_if #(
    parameter int W = 8
);
    logic [W-1:0] DATA_OUT;
    logic         VALID_OUT;
    logic         READY_IN;
    logic         FIRST_OUT;
    logic         LAST_OUT;

    modport master (
        output DATA_OUT,
        output VALID_OUT,
        input  READY_IN,
        output FIRST_OUT,
        output LAST_OUT
    );

    modport slave (
        input  DATA_OUT,
        input  VALID_OUT,
        output READY_IN,
        input  FIRST_OUT,
        input  LAST_OUT
    );
endinterface

// File: rtl/fifo_drain_serializer.sv
//------------------------------------------------------------------------------
// fifo_drain_serializer
//
// Drains a FIFO through its EMPTY_N/DEQ/D_OUT face and splits each wide word
// into `ratio` narrow beats on a valid/ready stream. The next word is dequeued
// in the same cycle the last beat of the current word is accepted, so a
// continuously ready consumer sees one beat every cycle across word
// boundaries.
//
// Parameters:
//   width_in   width of the FIFO word on D_IN
//   ratio      beats per word; must be >= 1 and divide width_in
//
// Ports:
//   CLK        clock, all logic on posedge
//   RST        synchronous, active-high reset
//   D_IN       head-of-FIFO data (upstream D_OUT)
//   EMPTY_N    upstream not-empty
//   DEQ        dequeue strobe to upstream (combinational)
//   CLR        synchronous flush of the held word
//   out_if     narrow output stream (master modport), W = width_in/ratio
//   dbg_state  current FSM state (0 = idle, 1 = holding a word)
//   dbg_beat   current beat counter
//
// Optional feature (macro FIFO_DRAIN_MSB_FIRST_EN):
//   defined    slices are emitted MSB-first
//   undefined  slices are emitted LSB-first
//   FIRST_OUT/LAST_OUT always mark emission order; timing is identical.
//------------------------------------------------------------------------------
module fifo_drain_serializer #(
    parameter int  width_in = 32,
    parameter int  ratio    = 4,
    localparam int W        = width_in / ratio,
    localparam int BW       = (ratio > 1) ? $clog2(ratio) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [width_in-1:0]   D_IN,
    input  logic                  EMPTY_N,
    output logic                  DEQ,
    input  logic                  CLR,
    fifo_drain_serializer_if.master out_if,
    output logic [0:0]            dbg_state,
    output logic [BW-1:0]         dbg_beat
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,  // no word held, output invalid
        ST_HOLD = 1'b1   // word held, beats being presented
    } state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [width_in-1:0] hold_q;

    logic                hold_v;
    logic                accept;
    logic                last;
    logic                deq_c;
    logic                load;
    logic [BW-1:0]       slice_idx;
    logic [W-1:0]        data_c;

    assign hold_v = (state_q == ST_HOLD);
    assign last   = (beat_q == BW'(ratio - 1));
    assign accept = hold_v & out_if.READY_IN;

    //--------------------------------------------------------------------------
    // Next-state / dequeue logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        load    = 1'b0;

        // Refill when empty, or when the final beat leaves this cycle.
        // RST and CLR block the dequeue so a flushed word is never replaced
        // by one popped during the flush.
        deq_c = EMPTY_N & ~RST & ~CLR & (~hold_v | (accept & last));

        if (deq_c) begin
            load    = 1'b1;
            state_d = ST_HOLD;
            beat_d  = '0;
        end else if (accept & ~last) begin
            beat_d  = beat_q + BW'(1);
        end else if (accept & last) begin
            state_d = ST_IDLE;
            beat_d  = '0;
        end
    end

    //--------------------------------------------------------------------------
    // State register (CLR behaves like RST for the control state)
    //--------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Hold register: contents only matter while hold_v is set, so no reset.
    always_ff @(posedge CLK) begin
        if (load) begin
            hold_q <= D_IN;
        end
    end

    //--------------------------------------------------------------------------
    // Slice selection
    //--------------------------------------------------------------------------
`ifdef FIFO_DRAIN_MSB_FIRST_EN
    assign slice_idx = BW'(ratio - 1) - beat_q;
`else
    assign slice_idx = beat_q;
`endif

    always_comb begin
        data_c = '0;
        for (int i = 0; i < ratio; i++) begin
            if (slice_idx == BW'(i)) begin
                data_c = hold_q[i*W +: W];
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign DEQ              = deq_c;
    assign out_if.VALID_OUT = hold_v;
    assign out_if.DATA_OUT  = data_c;
    assign out_if.FIRST_OUT = hold_v & (beat_q == '0);
    assign out_if.LAST_OUT  = hold_v & last;

    assign dbg_state = state_q;
    assign dbg_beat  = beat_q;

endmodule

// File: tb/tb_fifo_drain_serializer.sv
//------------------------------------------------------------------------------
// tb_fifo_drain_serializer
//
// Directed bench for fifo_drain_serializer. One instance uses width_in=32,
// ratio=4 and is driven from a per-cycle vector table; a second instance
// uses width_in=8, ratio=1 and is driven by a short hand-written sequence.
//------------------------------------------------------------------------------
module tb_fifo_drain_serializer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Main instance: width_in=32, ratio=4
    logic        rst;
    logic        clr;
    logic [31:0] d_in;
    logic        empty_n;
    logic        deq;
    logic [0:0]  dbg_state;
    logic [1:0]  dbg_beat;

    fifo_drain_serializer_if #(.W(8)) s_if ();

    fifo_drain_serializer #(.width_in(32), .ratio(4)) dut (
        .CLK       (CLK),
        .RST       (rst),
        .D_IN      (d_in),
        .EMPTY_N   (empty_n),
        .DEQ       (deq),
        .CLR       (clr),
        .out_if    (s_if),
        .dbg_state (dbg_state),
        .dbg_beat  (dbg_beat)
    );

    // Pass-through instance: width_in=8, ratio=1
    logic       r1_rst;
    logic       r1_clr;
    logic [7:0] r1_d_in;
    logic       r1_empty_n;
    logic       r1_deq;
    logic [0:0] r1_dbg_state;
    logic [0:0] r1_dbg_beat;

    fifo_drain_serializer_if #(.W(8)) r1_if ();

    fifo_drain_serializer #(.width_in(8), .ratio(1)) dut_r1 (
        .CLK       (CLK),
        .RST       (r1_rst),
        .D_IN      (r1_d_in),
        .EMPTY_N   (r1_empty_n),
        .DEQ       (r1_deq),
        .CLR       (r1_clr),
        .out_if    (r1_if),
        .dbg_state (r1_dbg_state),
        .dbg_beat  (r1_dbg_beat)
    );

    //--------------------------------------------------------------------------
    // Scoreboard counters and compare helper
    //--------------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    //--------------------------------------------------------------------------
    // Vector table: inputs held for one cycle, outputs compared mid-cycle
    //--------------------------------------------------------------------------
    typedef struct {
        logic        rst;
        logic        clr;
        logic        en;
        logic        rdy;
        logic [31:0] d;
        logic        e_deq;
        logic        e_v;
        logic [7:0]  e_data;
        logic        e_first;
        logic        e_last;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic c, input logic en, input logic rdy,
                       input logic [31:0] d, input logic e_deq, input logic e_v,
                       input logic [7:0] e_data, input logic e_first, input logic e_last);
        vec_t v;
        v.rst = r; v.clr = c; v.en = en; v.rdy = rdy; v.d = d;
        v.e_deq = e_deq; v.e_v = e_v; v.e_data = e_data;
        v.e_first = e_first; v.e_last = e_last;
        tbl.push_back(v);
    endtask

    task automatic fill_table();
        //   rst clr en rdy d              deq v  data  f  l
        // Reset held two cycles with a word waiting: no dequeue, no valid.
        add(1, 0, 1, 1, 32'hDDCCBBAA,   0, 0, 8'h00, 0, 0);
        add(1, 0, 1, 1, 32'hDDCCBBAA,   0, 0, 8'h00, 0, 0);
        // First cycle out of reset: dequeue immediately.
        add(0, 0, 1, 1, 32'hDDCCBBAA,   1, 0, 8'h00, 0, 0);
`ifdef FIFO_DRAIN_MSB_FIRST_EN
        add(0, 0, 0, 1, 32'h0,          0, 1, 8'hDD, 1, 0);
        add(0, 0, 0, 1, 32'h0,          0, 1, 8'hCC, 0, 0);
        add(0, 0, 0, 1, 32'h0,          0, 1, 8'hBB, 0, 0);
        add(0, 0, 0, 1, 32'h0,          0, 1, 8'hAA, 0, 1);
        add(0, 0, 0, 1, 32'h0,          0, 0, 8'h00, 0, 0);
`else
        // Single word, always ready.
        add(0, 0, 0, 1, 32'h0,          0, 1, 8'hAA, 1, 0);
        add(0, 0, 0, 1, 32'h0,          0, 1, 8'hBB, 0, 0);
        add(0, 0, 0, 1, 32'h0,          0, 1, 8'hCC, 0, 0);
        add(0, 0, 0, 1, 32'h0,          0, 1, 8'hDD, 0, 1);
        add(0, 0, 0, 1, 32'h0,          0, 0, 8'h00, 0, 0);
        // Two queued words, zero bubble across the boundary.
        add(0, 0, 1, 1, 32'h44332211,   1, 0, 8'h00, 0, 0);
        add(0, 0, 1, 1, 32'h88776655,   0, 1, 8'h11, 1, 0);
        add(0, 0, 1, 1, 32'h88776655,   0, 1, 8'h22, 0, 0);
        add(0, 0, 1, 1, 32'h88776655,   0, 1, 8'h33, 0, 0);
        add(0, 0, 1, 1, 32'h88776655,   1, 1, 8'h44, 0, 1);
        add(0, 0, 0, 1, 32'h0,          0, 1, 8'h55, 1, 0);
        add(0, 0, 0, 1, 32'h0,          0, 1, 8'h66, 0, 0);
        add(0, 0, 0, 1, 32'h0,          0, 1, 8'h77, 0, 0);
        add(0, 0, 0, 1, 32'h0,          0, 1, 8'h88, 0, 1);
        add(0, 0, 0, 1, 32'h0,          0, 0, 8'h00, 0, 0);
        // Backpressure on BB with the next word already waiting.
        add(0, 0, 1, 1, 32'hDDCCBBAA,   1, 0, 8'h00, 0, 0);
        add(0, 0, 1, 1, 32'h12345678,   0, 1, 8'hAA, 1, 0);
        add(0, 0, 1, 0, 32'h12345678,   0, 1, 8'hBB, 0, 0);
        add(0, 0, 1, 0, 32'h12345678,   0, 1, 8'hBB, 0, 0);
        add(0, 0, 1, 0, 32'h12345678,   0, 1, 8'hBB, 0, 0);
        add(0, 0, 1, 1, 32'h12345678,   0, 1, 8'hBB, 0, 0);
        add(0, 0, 1, 1, 32'h12345678,   0, 1, 8'hCC, 0, 0);
        add(0, 0, 1, 1, 32'h12345678,   1, 1, 8'hDD, 0, 1);
        // CLR after the second beat of 0x12345678 is accepted, with a
        // same-cycle accept of the third beat that must be overridden.
        add(0, 0, 1, 1, 32'hA5A4A3A2,   0, 1, 8'h78, 1, 0);
        add(0, 0, 1, 1, 32'hA5A4A3A2,   0, 1, 8'h56, 0, 0);
        add(0, 1, 1, 1, 32'hA5A4A3A2,   0, 1, 8'h34, 0, 0);
        add(0, 0, 1, 1, 32'hA5A4A3A2,   1, 0, 8'h00, 0, 0);
        add(0, 0, 0, 1, 32'h0,          0, 1, 8'hA2, 1, 0);
        add(0, 0, 0, 1, 32'h0,          0, 1, 8'hA3, 0, 0);
        add(0, 0, 0, 1, 32'h0,          0, 1, 8'hA4, 0, 0);
        add(0, 0, 0, 1, 32'h0,          0, 1, 8'hA5, 0, 1);
        add(0, 0, 0, 1, 32'h0,          0, 0, 8'h00, 0, 0);
        // RST mid-word drops the word and does not dequeue.
        add(0, 0, 1, 1, 32'hDDCCBBAA,   1, 0, 8'h00, 0, 0);
        add(0, 0, 1, 1, 32'h0BADF00D,   0, 1, 8'hAA, 1, 0);
        add(1, 0, 1, 1, 32'h0BADF00D,   0, 1, 8'hBB, 0, 0);
        add(0, 0, 0, 1, 32'h0,          0, 0, 8'h00, 0, 0);
`endif
    endtask

    //--------------------------------------------------------------------------
    // Stimulus
    //--------------------------------------------------------------------------
    initial begin
        rst = 1'b1; clr = 1'b0; d_in = '0; empty_n = 1'b0; s_if.READY_IN = 1'b0;
        r1_rst = 1'b1; r1_clr = 1'b0; r1_d_in = '0; r1_empty_n = 1'b0; r1_if.READY_IN = 1'b0;

        fill_table();
        @(posedge CLK);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge CLK);
            #1;
            rst            = tbl[i].rst;
            clr            = tbl[i].clr;
            empty_n        = tbl[i].en;
            d_in           = tbl[i].d;
            s_if.READY_IN  = tbl[i].rdy;
            @(negedge CLK);
            chk($sformatf("v%0d.deq", i),   {31'b0, deq},            {31'b0, tbl[i].e_deq});
            chk($sformatf("v%0d.valid", i), {31'b0, s_if.VALID_OUT}, {31'b0, tbl[i].e_v});
            chk($sformatf("v%0d.first", i), {31'b0, s_if.FIRST_OUT}, {31'b0, tbl[i].e_first});
            chk($sformatf("v%0d.last", i),  {31'b0, s_if.LAST_OUT},  {31'b0, tbl[i].e_last});
            if (tbl[i].e_v) begin
                chk($sformatf("v%0d.data", i), {24'b0, s_if.DATA_OUT}, {24'b0, tbl[i].e_data});
            end
        end

        // ratio=1 pass-through: 0x1, 0x2, 0x3 on consecutive cycles.
        @(posedge CLK); #1;
        r1_rst = 1'b1; r1_empty_n = 1'b1; r1_d_in = 8'h01; r1_if.READY_IN = 1'b1;
        @(negedge CLK);
        chk("r1.rst.deq",   {31'b0, r1_deq},            32'd0);
        chk("r1.rst.valid", {31'b0, r1_if.VALID_OUT},   32'd0);

        @(posedge CLK); #1;
        r1_rst = 1'b0;
        @(negedge CLK);
        chk("r1.c0.deq",   {31'b0, r1_deq},          32'd1);
        chk("r1.c0.valid", {31'b0, r1_if.VALID_OUT}, 32'd0);

        for (int k = 1; k <= 3; k++) begin
            @(posedge CLK); #1;
            if (k < 3) begin
                r1_d_in    = 8'(k + 1);
                r1_empty_n = 1'b1;
            end else begin
                r1_d_in    = 8'h00;
                r1_empty_n = 1'b0;
            end
            @(negedge CLK);
            chk($sformatf("r1.c%0d.valid", k), {31'b0, r1_if.VALID_OUT}, 32'd1);
            chk($sformatf("r1.c%0d.data", k),  {24'b0, r1_if.DATA_OUT},  k);
            chk($sformatf("r1.c%0d.first", k), {31'b0, r1_if.FIRST_OUT}, 32'd1);
            chk($sformatf("r1.c%0d.last", k),  {31'b0, r1_if.LAST_OUT},  32'd1);
            chk($sformatf("r1.c%0d.deq", k),   {31'b0, r1_deq},          (k < 3) ? 32'd1 : 32'd0);
        end

        @(posedge CLK); #1;
        @(negedge CLK);
        chk("r1.end.valid", {31'b0, r1_if.VALID_OUT}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_drain_serializer.md
Name: fifo_drain_serializer

Overview:
- Reader-side companion to the depth-2 FIFO primitives: drains a FIFO through its EMPTY_N/DEQ/D_OUT face and serializes each wide word into RATIO narrow beats on a valid/ready stream.
- Used between wide internal FIFOs and narrow worker/DMA output ports.
- Zero-bubble operation: sustains one output beat per cycle across word boundaries.

Parameters:
- width_in, 32: width of FIFO word consumed from D_IN.
- ratio, 4: beats per word. Must be >= 1 and divide width_in. Output width = width_in/ratio.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  reset; synchronous, active-high.
- D_IN  in  width_in  head-of-FIFO data (upstream D_OUT).
- EMPTY_N  in  1  upstream not-empty (upstream EMPTY_N).
- DEQ  out  1  dequeue strobe to upstream; combinational.
- CLR  in  1  synchronous flush of held word.
- DATA_OUT  out  width_in/ratio  current beat.
- VALID_OUT  out  1  beat valid.
- READY_IN  in  1  downstream accepts beat.
- FIRST_OUT  out  1  beat is slice 0 of its word.
- LAST_OUT  out  1  beat is slice ratio-1 of its word.

Behaviour:
- State: hold register (width_in), hold_v flag, beat counter (max(1,clog2(ratio)) bits, range 0..ratio-1).
- Reset values: hold_v=0, beat=0, VALID_OUT=0, DEQ=0. Hold register contents are don't-care and are not reset.
- accept = VALID_OUT & READY_IN.
- last = (beat == ratio-1).
- DEQ = EMPTY_N & !RST & !CLR & (!hold_v | (accept & last)).
  - DEQ is never asserted while EMPTY_N=0; no dequeue from empty.
- On DEQ: hold <= D_IN, beat <= 0, hold_v <= 1.
- On accept & !last: beat <= beat+1.
- On accept & last & !DEQ: hold_v <= 0, beat <= 0.
- VALID_OUT = hold_v.
- DATA_OUT = hold[beat*W +: W], with W = width_in/ratio. Slice order is LSB-first.
- FIRST_OUT = hold_v & (beat==0).
- LAST_OUT = hold_v & last.
- Latency: word at FIFO head with hold empty → DEQ in the same cycle → VALID_OUT and first beat on the next cycle.
- Back-to-back words: the last beat's accept and the DEQ of the next word occur in the same cycle, so there is no idle cycle between words.
- Backpressure: while VALID_OUT & !READY_IN, DATA_OUT, FIRST_OUT, LAST_OUT and beat are held stable and DEQ=0.
- ratio=1: each word passes through as a single beat; FIRST_OUT=LAST_OUT=1 on every beat. Throughput is 1 word per cycle when READY_IN=1.
- CLR (when RST=0):
  - Next cycle: hold_v=0, beat=0.
  - DEQ is forced 0 in the CLR cycle.
  - A partially sent word is discarded with no further beats.
  - CLR overrides a same-cycle accept.
- RST mid-word: same as CLR; upstream is not dequeued during reset.
- Upstream goes empty: VALID_OUT drops the cycle after the last beat is accepted.

Optional Feature:
- Macro: FIFO_DRAIN_MSB_FIRST_EN.
- Defined: slices are emitted MSB-first, DATA_OUT = hold[(ratio-1-beat)*W +: W]. FIRST_OUT and LAST_OUT still mark emission order.
- Undefined: LSB-first as above.
- All other timing is identical.

Test Plan:
- width_in=32, ratio=4, READY_IN=1, single word 0xDDCCBBAA:
  - DEQ pulses once.
  - Beats AA,BB,CC,DD on 4 consecutive cycles starting 1 cycle after DEQ.
  - FIRST_OUT on AA, LAST_OUT on DD.
  - VALID_OUT=0 the following cycle.
- Two queued words 0x44332211, 0x88776655, READY_IN=1:
  - 8 consecutive valid beats 11..88 with no gap.
  - DEQ high in cycle 0 and again in the cycle beat 44 is accepted.
- Backpressure: READY_IN low for 3 cycles while beat BB is presented:
  - DATA_OUT=BB, VALID_OUT=1, DEQ=0 throughout.
  - Resumes with CC after READY_IN rises.
- CLR asserted after beat BB is accepted:
  - VALID_OUT=0 next cycle, no CC/DD emitted, no DEQ in the CLR cycle.
  - Next queued word starts with FIRST_OUT at slice 0.
- RST asserted for 2 cycles with EMPTY_N=1:
  - DEQ=0 and VALID_OUT=0 during reset.
  - First DEQ in the first cycle after RST drops.
  - ratio=1 build streams 0x1,0x2,0x3 on consecutive cycles with FIRST_OUT=LAST_OUT=1.
- FIFO_DRAIN_MSB_FIRST_EN defined, word 0xDDCCBBAA:
  - Beats DD,CC,BB,AA.
  - FIRST_OUT on DD, LAST_OUT on AA.
